mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-port data memory (memory_main) between the fetch stage (read-only) and the
//   memory-access stage (read/write). Grants at most one access per cycle and tracks in-flight
//   synchronous reads so returned data reaches the correct requester. Bounds fetch starvation.
//   Sits between the IF/MEM stages and memory_main; drives its addr/data/wr_en ports.
// PARAMETERS
//   ADDR_W       20  address width
//   DATA_W       20  data/instruction width
//   READ_LAT     1   memory read latency in cycles (>=1); q valid READ_LAT cycles after addr
//   MAX_IF_WAIT  4   consecutive denied IF cycles after which IF wins the next contention (>=1)
// PORTS
//   clock       in   1       single clock, all state on rising edge
//   reset       in   1       synchronous, active-high
//   if_req      in   1       fetch read request; held until if_gnt
//   if_addr     in   ADDR_W  fetch address
//   if_gnt      out  1       fetch request accepted this cycle
//   if_rvalid   out  1       if_rdata valid this cycle
//   if_rdata    out  DATA_W  fetch read data
//   mem_req     in   1       MEM-stage request; held until mem_gnt
//   mem_we      in   1       1 = write, 0 = read
//   mem_addr    in   ADDR_W  MEM-stage address
//   mem_wdata   in   DATA_W  MEM-stage write data
//   mem_gnt     out  1       MEM request accepted this cycle (0 = MEM stage stalls)
//   mem_rvalid  out  1       mem_rdata valid this cycle
//   mem_rdata   out  DATA_W  MEM-stage read data
//   ram_addr    out  ADDR_W  to memory_main addr
//   ram_data    out  DATA_W  to memory_main data
//   ram_wr_en   out  1       to memory_main wr_en
//   ram_q       in   DATA_W  from memory_main q
//   busy        out  1       any read in flight
// BEHAVIOUR
//   - Grant (combinational from requests and registered state, same cycle as req):
//     only one req -> that requester wins; both -> MEM wins unless starve_cnt == MAX_IF_WAIT,
//     then IF wins. Exactly one of if_gnt/mem_gnt high when any req high; none when no req.
//   - Memory drive: ram_addr = winner's address; ram_wr_en = mem_gnt & mem_we;
//     ram_data = mem_wdata. With no grant: ram_addr = 0, ram_wr_en = 0, ram_data = 0.
//   - Starvation counter starve_cnt (clog2(MAX_IF_WAIT+1) bits): +1 when if_req & ~if_gnt,
//     saturating at MAX_IF_WAIT; cleared to 0 on if_gnt or ~if_req.
//   - Read tracking: shift register of READ_LAT stages, each {valid, owner}. Stage 0 loads
//     {1, IF} on if_gnt, {1, MEM} on mem_gnt & ~mem_we, else {0, x}. Shifts every cycle.
//     A write occupies the port but inserts no valid tag.
//   - Return: at last stage valid: owner IF -> if_rvalid = 1; owner MEM -> mem_rvalid = 1.
//     if_rdata = mem_rdata = ram_q (passthrough); consumers qualify with rvalid.
//   - Pipelined: a new access may be granted every cycle, including while reads are in flight;
//     returns arrive in grant order, one per cycle max. busy = OR of tag valid bits.
//   - Write followed by read of same address next cycle: ordering preserved by memory_main;
//     no forwarding here.
//   - Reset (sync, active-high): all tag stages invalid, starve_cnt = 0. Registered outputs
//     if_rvalid, mem_rvalid, busy = 0 on the cycle after reset is sampled. While reset is high,
//     if_gnt = mem_gnt = ram_wr_en = 0 and ram_addr = ram_data = 0. Reads in flight when
//     reset asserts are discarded: no rvalid for them after reset.
//   - Requests dropped before grant are legal; no state retained for them.
// TESTING
//   1 reset held 3 cycles with both reqs high -> all gnt/rvalid/ram_wr_en/busy = 0.
//   2 IF read only, if_addr=0x00010, ram_q=0x12345 next cycle -> if_gnt cycle 0;
//     if_rvalid=1, if_rdata=0x12345 cycle 1; mem_rvalid=0.
//   3 both read same cycle (mem_addr=0x00020, if_addr=0x00004) -> mem_gnt, ram_addr=0x00020
//     cycle 0; if_gnt, ram_addr=0x00004 cycle 1; mem_rvalid cycle 1, if_rvalid cycle 2.
//   4 mem_req held 8 cycles, if_req held -> IF denied cycles 0-3, if_gnt cycle 4, MEM resumes
//     cycle 5; starve_cnt back to 0.
//   5 MEM write addr 0x00020, data 0xABCDE -> ram_wr_en=1 same cycle, no rvalid;
//     IF read 0x00020 next cycle returns 0xABCDE.
//   6 IF read granted, reset asserted next cycle -> if_rvalid stays 0; busy=0 after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data memory between instruction fetch and the MEM stage,
// tagging in-flight reads so returned data is steered to the requester that issued it.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 20,
    parameter int unsigned READ_LAT    = 1,
    parameter int unsigned MAX_IF_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wr_en,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    localparam int unsigned CNT_W   = $clog2(MAX_IF_WAIT + 1);
    localparam logic        OWN_IF  = 1'b0;
    localparam logic        OWN_MEM = 1'b1;

    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic [READ_LAT-1:0] tag_valid_q;
    logic [READ_LAT-1:0] tag_owner_q;
    logic                starve_max;
    logic                new_valid;
    logic                new_owner;

    assign starve_max = (starve_cnt_q == CNT_W'(MAX_IF_WAIT));

    // MEM has priority on contention unless fetch has been starved long enough.
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (!reset) begin
            if (if_req && (!mem_req || starve_max)) begin
                if_gnt = 1'b1;
            end else if (mem_req) begin
                mem_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_data  = '0;
        ram_wr_en = 1'b0;
        if (if_gnt) begin
            ram_addr = if_addr;
            ram_data = mem_wdata;
        end else if (mem_gnt) begin
            ram_addr  = mem_addr;
            ram_data  = mem_wdata;
            ram_wr_en = mem_we;
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (if_req && !if_gnt) begin
            starve_cnt_d = starve_max ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    // Writes occupy the port but never produce a return, so they insert no valid tag.
    assign new_valid = if_gnt | (mem_gnt & ~mem_we);
    assign new_owner = mem_gnt ? OWN_MEM : OWN_IF;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
            tag_valid_q  <= '0;
            tag_owner_q  <= '0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            tag_valid_q[0] <= new_valid;
            tag_owner_q[0] <= new_owner;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_owner_q[i] <= tag_owner_q[i-1];
            end
        end
    end

    // Gating with reset drops returns of reads that were in flight when reset arrived.
    assign if_rvalid  = ~reset & tag_valid_q[READ_LAT-1] & (tag_owner_q[READ_LAT-1] == OWN_IF);
    assign mem_rvalid = ~reset & tag_valid_q[READ_LAT-1] & (tag_owner_q[READ_LAT-1] == OWN_MEM);
    assign if_rdata   = ram_q;
    assign mem_rdata  = ram_q;
    assign busy       = ~reset & (|tag_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous-read memory model on the RAM side.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [19:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [19:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [19:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [19:0] mem_rdata;
    logic [19:0] ram_addr;
    logic [19:0] ram_data;
    logic        ram_wr_en;
    logic [19:0] ram_q;
    logic        busy;
    logic        load;
    logic [19:0] ram [256];

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_wr_en  (ram_wr_en),
        .ram_q      (ram_q),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Read-old-data single-port RAM, latency 1; preloaded while load is high.
    always @(posedge clock) begin
        if (load) begin
            ram[8'h04] <= 20'h00444;
            ram[8'h10] <= 20'h12345;
            ram[8'h20] <= 20'h0BEEF;
        end else if (ram_wr_en) begin
            ram[ram_addr[7:0]] <= ram_data;
        end
        ram_q <= ram[ram_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        load      = 1'b1;
        if_req    = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        if_addr   = 20'h00004;
        mem_addr  = 20'h00020;
        mem_wdata = 20'h11111;

        // reset held with both requests high
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            check("rst_if_gnt", 32'(if_gnt), 32'd0);
            check("rst_mem_gnt", 32'(mem_gnt), 32'd0);
            check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
            check("rst_mem_rvalid", 32'(mem_rvalid), 32'd0);
            check("rst_wr_en", 32'(ram_wr_en), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_ram_addr", 32'(ram_addr), 32'd0);
            check("rst_ram_data", 32'(ram_data), 32'd0);
        end

        tick();
        reset   = 1'b0;
        load    = 1'b0;
        if_req  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        #1;
        check("idle_gnt", 32'({if_gnt, mem_gnt}), 32'd0);
        check("idle_ram_addr", 32'(ram_addr), 32'd0);
        check("idle_ram_data", 32'(ram_data), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // IF read only
        tick();
        if_req  = 1'b1;
        if_addr = 20'h00010;
        #1;
        check("t2_if_gnt", 32'(if_gnt), 32'd1);
        check("t2_mem_gnt", 32'(mem_gnt), 32'd0);
        check("t2_ram_addr", 32'(ram_addr), 32'h00010);
        tick();
        if_req = 1'b0;
        #1;
        check("t2_if_rvalid", 32'(if_rvalid), 32'd1);
        check("t2_if_rdata", 32'(if_rdata), 32'h12345);
        check("t2_mem_rvalid", 32'(mem_rvalid), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        tick();
        #1;
        check("t2_busy_clr", 32'(busy), 32'd0);
        check("t2_if_rvalid_clr", 32'(if_rvalid), 32'd0);

        // both read the same cycle
        tick();
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 20'h00020;
        if_req   = 1'b1;
        if_addr  = 20'h00004;
        #1;
        check("t3_c0_mem_gnt", 32'(mem_gnt), 32'd1);
        check("t3_c0_if_gnt", 32'(if_gnt), 32'd0);
        check("t3_c0_ram_addr", 32'(ram_addr), 32'h00020);
        tick();
        mem_req = 1'b0;
        #1;
        check("t3_c1_if_gnt", 32'(if_gnt), 32'd1);
        check("t3_c1_ram_addr", 32'(ram_addr), 32'h00004);
        check("t3_c1_mem_rvalid", 32'(mem_rvalid), 32'd1);
        check("t3_c1_mem_rdata", 32'(mem_rdata), 32'h0BEEF);
        check("t3_c1_if_rvalid", 32'(if_rvalid), 32'd0);
        tick();
        if_req = 1'b0;
        #1;
        check("t3_c2_if_rvalid", 32'(if_rvalid), 32'd1);
        check("t3_c2_if_rdata", 32'(if_rdata), 32'h00444);
        check("t3_c2_mem_rvalid", 32'(mem_rvalid), 32'd0);

        // starvation bound: IF wins on the fifth contended cycle
        for (int c = 0; c < 8; c++) begin
            tick();
            mem_req  = 1'b1;
            mem_we   = 1'b0;
            mem_addr = 20'h00030;
            if_req   = (c <= 4);
            if_addr  = 20'h00040;
            #1;
            check($sformatf("t4_if_gnt_c%0d", c), 32'(if_gnt), (c == 4) ? 32'd1 : 32'd0);
            check($sformatf("t4_mem_gnt_c%0d", c), 32'(mem_gnt), (c == 4) ? 32'd0 : 32'd1);
            if (c == 5) begin
                check("t4_starve_clr", 32'(dut.starve_cnt_q), 32'd0);
                check("t4_if_rvalid", 32'(if_rvalid), 32'd1);
            end
        end
        tick();
        mem_req = 1'b0;
        #1;
        check("t4_tail_mem_rvalid", 32'(mem_rvalid), 32'd1);

        // write, then IF read of the same address
        tick();
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 20'h00020;
        mem_wdata = 20'hABCDE;
        #1;
        check("t5_wr_en", 32'(ram_wr_en), 32'd1);
        check("t5_mem_gnt", 32'(mem_gnt), 32'd1);
        check("t5_ram_data", 32'(ram_data), 32'hABCDE);
        check("t5_ram_addr", 32'(ram_addr), 32'h00020);
        tick();
        mem_req = 1'b0;
        mem_we  = 1'b0;
        if_req  = 1'b1;
        if_addr = 20'h00020;
        #1;
        check("t5_if_gnt", 32'(if_gnt), 32'd1);
        check("t5_wr_en_off", 32'(ram_wr_en), 32'd0);
        check("t5_no_rvalid", 32'({if_rvalid, mem_rvalid}), 32'd0);
        check("t5_no_busy", 32'(busy), 32'd0);
        tick();
        if_req = 1'b0;
        #1;
        check("t5_if_rvalid", 32'(if_rvalid), 32'd1);
        check("t5_if_rdata", 32'(if_rdata), 32'hABCDE);

        // reset discards an in-flight read
        tick();
        if_req  = 1'b1;
        if_addr = 20'h00010;
        #1;
        check("t6_if_gnt", 32'(if_gnt), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        check("t6_rst_if_gnt", 32'(if_gnt), 32'd0);
        check("t6_rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        reset  = 1'b0;
        if_req = 1'b0;
        #1;
        check("t6_post_if_rvalid", 32'(if_rvalid), 32'd0);
        check("t6_post_mem_rvalid", 32'(mem_rvalid), 32'd0);
        check("t6_post_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
